// File: rtl/usb_pkg.sv
// Shared constants and types for the USB full-speed receive path.
// PIDs, receive FSM states and default framing parameters.
package usb_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE      = 8'h80;
  localparam int         DEF_MAX_DATA_BYTES = 64;
  localparam logic [6:0] FIFO_FULL_LVL      = 7'd64;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_HSHK,
    ST_ERR_WAIT
  } rx_state_t;

  // Upper nibble of a PID byte is the complement of the lower nibble.
  function automatic logic pid_check(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/usb_rx_byte_pipe.sv
// Two-deep byte holding register for the data payload path.
// push shifts din in, dout is the oldest byte when full, clr empties it.
module usb_rx_byte_pipe (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  logic       clr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full
);

  logic [7:0] h0;
  logic [7:0] h1;
  logic [1:0] lvl;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      h0  <= '0;
      h1  <= '0;
      lvl <= '0;
    end else if (clr) begin
      lvl <= '0;
    end else if (push) begin
      h0 <= din;
      h1 <= h0;
      if (lvl != 2'd2) lvl <= lvl + 2'd1;
    end
  end

  assign dout = h1;
  assign full = (lvl == 2'd2);

endmodule

// File: rtl/usb_rx_controller.sv
// USB full-speed receive packet sequencer: SYNC/PID check, token decode,
// payload framing into the RX FIFO with the CRC16 tail withheld.
module usb_rx_controller
  import usb_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         MAX_DATA_BYTES = DEF_MAX_DATA_BYTES
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_detect,
  input  logic       rx_byte_valid,
  input  logic [7:0] rx_byte,
  input  logic       eop_detected,
  input  logic       line_error,
  input  logic [6:0] buffer_occupancy,
  output logic [7:0] rx_packet_data,
  output logic       store_rx_packet_data,
  output logic       flush,
  output logic       rx_error,
  output logic       rx_transfer_active,
  output logic       rx_data_ready,
  output logic [3:0] rx_packet,
  output logic [6:0] rx_token_addr,
  output logic [3:0] rx_token_endp
);

  // Bytes counted in DATA include the two held CRC bytes.
  localparam logic [6:0] OVF_CNT = 7'(MAX_DATA_BYTES + 2);

  rx_state_t  state;
  rx_state_t  st_b;
  rx_state_t  nstate;
  logic [6:0] cnt;
  logic [6:0] cnt_b;
  logic [3:0] pid_r;
  logic [3:0] pid_n;
  logic [7:0] tok_lo;
  logic [2:0] tok_hi;
  logic [2:0] tok_hi_n;

  logic err;
  logic good;
  logic push;
  logic store;
  logic fl;
  logic clr;
  logic pid_ld;
  logic tok_ld;

  logic [7:0] pipe_dout;
  logic       pipe_full;

  logic pid_good;
  logic is_tok;
  logic is_dat;
  logic is_hsk;

  assign pid_good = pid_check(rx_byte);
  assign is_tok = (rx_byte[3:0] == PID_OUT)
               || (rx_byte[3:0] == PID_IN);
  assign is_dat = (rx_byte[3:0] == PID_DATA0)
               || (rx_byte[3:0] == PID_DATA1);
  assign is_hsk = (rx_byte[3:0] == PID_ACK)
               || (rx_byte[3:0] == PID_NAK)
               || (rx_byte[3:0] == PID_STALL);

  usb_rx_byte_pipe u_pipe (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .clr   (clr),
    .din   (rx_byte),
    .dout  (pipe_dout),
    .full  (pipe_full)
  );

  // Byte is applied first (st_b/cnt_b), then EOP is judged on the result.
  always_comb begin
    st_b   = state;
    cnt_b  = cnt;
    err    = 1'b0;
    good   = 1'b0;
    push   = 1'b0;
    store  = 1'b0;
    fl     = 1'b0;
    clr    = 1'b0;
    pid_ld = 1'b0;
    tok_ld = 1'b0;
    if (state == ST_IDLE) cnt_b = '0;
    if (rx_byte_valid) begin
      unique case (state)
        ST_SYNC: begin
          if (rx_byte == SYNC_BYTE) st_b = ST_PID;
          else err = 1'b1;
        end
        ST_PID: begin
          clr    = 1'b1;
          pid_ld = 1'b1;
          cnt_b  = '0;
          unique case (1'b1)
            pid_good && is_tok: st_b = ST_TOKEN;
            pid_good && is_dat: begin
              st_b = ST_DATA;
              fl   = (buffer_occupancy != '0);
            end
            pid_good && is_hsk: st_b = ST_HSHK;
            default: err = 1'b1;
          endcase
        end
        ST_TOKEN: begin
          if (cnt == 7'd2) begin
            err = 1'b1;
          end else begin
            cnt_b  = cnt + 7'd1;
            tok_ld = 1'b1;
          end
        end
        ST_DATA: begin
          push  = 1'b1;
          cnt_b = (cnt == 7'h7F) ? cnt : cnt + 7'd1;
          if (pipe_full) begin
            if (buffer_occupancy == FIFO_FULL_LVL) err = 1'b1;
            else store = 1'b1;
          end
        end
        ST_HSHK: err = 1'b1;
        default: ;
      endcase
    end
    if (state == ST_DATA && cnt > OVF_CNT) err = 1'b1;
    if (line_error && state != ST_IDLE) err = 1'b1;
    if (eop_detected && !err
        && state != ST_IDLE && state != ST_ERR_WAIT) begin
      good = (st_b == ST_TOKEN && cnt_b == 7'd2)
          || (st_b == ST_DATA && cnt_b >= 7'd2)
          || (st_b == ST_HSHK);
      err  = !good;
    end
    if (err) begin
      store = 1'b0;
      fl    = 1'b0;
      push  = 1'b0;
    end
    if (err) nstate = eop_detected ? ST_IDLE : ST_ERR_WAIT;
    else if (good) nstate = ST_IDLE;
    else if (state == ST_ERR_WAIT && eop_detected) nstate = ST_IDLE;
    else if (state == ST_IDLE && start_detect) nstate = ST_SYNC;
    else nstate = st_b;
  end

  assign pid_n    = pid_ld ? rx_byte[3:0] : pid_r;
  assign tok_hi_n = (tok_ld && cnt == 7'd1) ? rx_byte[2:0] : tok_hi;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      pid_r                <= '0;
      tok_lo               <= '0;
      tok_hi               <= '0;
      rx_packet_data       <= '0;
      store_rx_packet_data <= 1'b0;
      flush                <= 1'b0;
      rx_error             <= 1'b0;
      rx_transfer_active   <= 1'b0;
      rx_data_ready        <= 1'b0;
      rx_packet            <= '0;
      rx_token_addr        <= '0;
      rx_token_endp        <= '0;
    end else begin
      state                <= nstate;
      cnt                  <= cnt_b;
      pid_r                <= pid_n;
      tok_hi               <= tok_hi_n;
      store_rx_packet_data <= store;
      flush                <= fl;
      rx_transfer_active   <= (nstate != ST_IDLE);
      if (tok_ld && cnt == 7'd0) tok_lo <= rx_byte;
      if (store) rx_packet_data <= pipe_dout;
      if (state == ST_IDLE && start_detect) begin
        rx_error      <= 1'b0;
        rx_data_ready <= 1'b0;
      end
      if (err) rx_error <= 1'b1;
      if (good) begin
        rx_packet <= pid_n;
        if (st_b == ST_TOKEN) begin
          rx_token_addr <= tok_lo[6:0];
          rx_token_endp <= {tok_hi_n, tok_lo[7]};
        end
        if (st_b == ST_DATA) rx_data_ready <= 1'b1;
      end
    end
  end

endmodule
